// File: rtl/soc_io.sv
// soc_io: memory-mapped LED register, free-running cycle counter, rxd status and 8N1 UART transmitter.
// Reads return registered data one cycle after the strobe; UART writes arriving while busy are dropped.
module soc_io #(
  parameter int NUM_LEDS = 5,
  parameter int CLK_HZ   = 12000000,
  parameter int BAUD     = 115200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                io_sel,
  input  logic [31:0]         io_addr,
  input  logic [31:0]         io_wdata,
  input  logic                io_wstrb,
  input  logic                io_rstrb,
  output logic [31:0]         io_rdata,
  output logic [NUM_LEDS-1:0] leds,
  input  logic                rxd,
  output logic                txd
);
  localparam int DIV   = CLK_HZ / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

  logic                wr_en;
  logic                rd_en;
  logic [1:0]          reg_sel;
  logic                tx_wr;
  logic                tx_busy;

  logic [NUM_LEDS-1:0] leds_q, leds_d;
  logic [31:0]         cycles_q;
  logic [31:0]         rdata_q, rdata_d;
  logic [1:0]          sync_q;

  tx_state_e           state_q, state_d;
  logic [CNT_W-1:0]    baud_cnt_q, baud_cnt_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [7:0]          data_q, data_d;
  logic                txd_q, txd_d;

  logic                unused_bits;

  assign wr_en   = io_sel & io_wstrb;
  assign rd_en   = io_sel & io_rstrb;
  assign reg_sel = io_addr[3:2];
  assign tx_wr   = wr_en && (reg_sel == 2'd1);
  assign tx_busy = (state_q != IDLE);

  assign unused_bits = ^{io_addr[31:4], io_addr[1:0], io_wdata};

  always_comb begin
    leds_d = leds_q;
    if (wr_en && (reg_sel == 2'd0)) leds_d = io_wdata[NUM_LEDS-1:0];
  end

  // Read mux samples pre-edge state, so a same-cycle write is not visible yet.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      case (reg_sel)
        2'd0:    rdata_d = 32'(leds_q);
        2'd1:    rdata_d = 32'd0;
        2'd2:    rdata_d = {30'd0, sync_q[1], tx_busy};
        default: rdata_d = cycles_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      leds_q   <= '0;
      cycles_q <= '0;
      rdata_q  <= '0;
      sync_q   <= '0;
    end else begin
      leds_q   <= leds_d;
      cycles_q <= cycles_q + 32'd1;
      rdata_q  <= rdata_d;
      sync_q   <= {sync_q[0], rxd};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      data_q     <= '0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      data_q     <= data_d;
      txd_q      <= txd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    data_d     = data_q;
    if (state_q == IDLE) begin
      if (tx_wr) begin
        state_d    = START;
        baud_cnt_d = '0;
        data_d     = io_wdata[7:0];
      end
    end else if (baud_cnt_q == CNT_W'(DIV - 1)) begin
      baud_cnt_d = '0;
      case (state_q)
        START: begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
        DATA: begin
          if (bit_idx_q == 3'd7) state_d = STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end
        default: state_d = IDLE;
      endcase
    end else begin
      baud_cnt_d = baud_cnt_q + CNT_W'(1);
    end
  end

  // Line level follows the next state so the registered txd lines up with the FSM.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = data_d[bit_idx_d];
      default: txd_d = 1'b1;
    endcase
  end

  assign io_rdata = rdata_q;
  assign leds     = leds_q;
  assign txd      = txd_q;

endmodule

// File: tb/tb_soc_io.sv
// Directed bench for soc_io with a frame-level reference model checked every cycle.
module tb_soc_io;
  localparam int DIV = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        io_sel;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic        io_wstrb;
  logic        io_rstrb;
  logic [31:0] io_rdata;
  logic [4:0]  leds;
  logic        rxd;
  logic        txd;

  always #5 clk = ~clk;

  soc_io #(.NUM_LEDS(5), .CLK_HZ(1000), .BAUD(100)) dut (
    .clk      (clk),
    .rst      (rst),
    .io_sel   (io_sel),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_wstrb (io_wstrb),
    .io_rstrb (io_rstrb),
    .io_rdata (io_rdata),
    .leds     (leds),
    .rxd      (rxd),
    .txd      (txd)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference model: a frame is a 10-bit vector plus the number of cycles it still occupies.
  bit          m_valid = 1'b0;
  bit          cyc_forced = 1'b0;
  logic [4:0]  m_leds;
  logic [31:0] m_cyc;
  logic [31:0] m_rdata;
  logic [1:0]  m_rx;
  int          m_left;
  logic [9:0]  m_frame;

  always @(posedge clk) begin
    logic busy;
    if (rst) begin
      m_valid <= 1'b1;
      m_leds  <= '0;
      m_cyc   <= '0;
      m_rdata <= '0;
      m_rx    <= 2'b00;
      m_left  <= 0;
    end else begin
      busy = (m_left != 0);
      if (io_sel && io_rstrb) begin
        case (io_addr[3:2])
          2'd0:    m_rdata <= {27'd0, m_leds};
          2'd1:    m_rdata <= 32'd0;
          2'd2:    m_rdata <= {30'd0, m_rx[1], busy};
          default: m_rdata <= m_cyc;
        endcase
      end
      if (io_sel && io_wstrb && io_addr[3:2] == 2'd0) m_leds <= io_wdata[4:0];
      if (busy) m_left <= m_left - 1;
      else if (io_sel && io_wstrb && io_addr[3:2] == 2'd1) begin
        m_frame <= {1'b1, io_wdata[7:0], 1'b0};
        m_left  <= 10 * DIV;
      end
      m_rx  <= {m_rx[0], rxd};
      m_cyc <= cyc_forced ? 32'hFFFF_FFFE : m_cyc + 32'd1;
    end
  end

  always @(negedge clk) begin
    logic et;
    if (m_valid) begin
      et = (m_left == 0) ? 1'b1 : m_frame[(10 * DIV - m_left) / DIV];
      chk("model_rdata", io_rdata, m_rdata);
      chk("model_leds", {27'd0, leds}, {27'd0, m_leds});
      chk("model_txd", {31'd0, txd}, {31'd0, et});
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    io_sel = 1'b1; io_wstrb = 1'b1; io_rstrb = 1'b0; io_addr = a; io_wdata = d;
    @(negedge clk);
    io_sel = 1'b0; io_wstrb = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    io_sel = 1'b1; io_rstrb = 1'b1; io_wstrb = 1'b0; io_addr = a;
    @(negedge clk);
    io_sel = 1'b0; io_rstrb = 1'b0;
    v = io_rdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] v;
  logic [9:0]  pat;
  int          busy_cnt;
  int          low_cnt;

  initial begin
    rst = 1'b1; io_sel = 1'b0; io_addr = '0; io_wdata = '0;
    io_wstrb = 1'b0; io_rstrb = 1'b0; rxd = 1'b1;
    pat = 10'b1101001010;
    idle(3);
    rst = 1'b0;

    // Reset state
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_leds", {27'd0, leds}, 32'd0);
    rd(32'h0, v);  chk("rst_rd_leds", v, 32'd0);
    rd(32'h4, v);  chk("rst_rd_uart", v, 32'd0);
    rd(32'h8, v);  chk("rst_rd_status", v, 32'h2);
    rd(32'hC, v);  chk("rst_rd_cycles_small", {31'd0, v < 32'd16}, 32'd1);

    // LED register, upper bits ignored, read-during-write returns old value
    wr(32'h0, 32'hFFFF_FFF5);
    chk("led_write", {27'd0, leds}, 32'h15);
    rd(32'h0, v);  chk("led_read", v, 32'h15);
    io_sel = 1'b1; io_wstrb = 1'b1; io_rstrb = 1'b1; io_addr = 32'h0; io_wdata = 32'h0A;
    @(negedge clk);
    io_sel = 1'b0; io_wstrb = 1'b0; io_rstrb = 1'b0;
    chk("led_rw_old", io_rdata, 32'h15);
    chk("led_rw_new", {27'd0, leds}, 32'h0A);

    // Synchronised rxd
    rxd = 1'b0;
    idle(3);
    rd(32'h8, v);  chk("rxd_low_status", v, 32'h0);
    rxd = 1'b1;
    idle(3);

    // Writes to read-only registers
    wr(32'h8, 32'hFFFF_FFFF);
    rd(32'h8, v);  chk("status_ro", v, 32'h2);
    wr(32'hC, 32'h0);
    rd(32'hC, v);

    // Single frame, polling STATUS every cycle
    wr(32'h4, 32'hA5);
    io_sel = 1'b1; io_rstrb = 1'b1; io_addr = 32'h8;
    busy_cnt = 0;
    for (int k = 0; k < 130; k++) begin
      if (k < 100 && (k % 10) == 5)
        chk($sformatf("frame_bit%0d", k / 10), {31'd0, txd}, {31'd0, pat[k / 10]});
      @(negedge clk);
      if (io_rdata[0]) busy_cnt++;
    end
    io_sel = 1'b0; io_rstrb = 1'b0;
    chk("busy_cycles", 32'(busy_cnt), 32'd100);

    // Busy drop, drop on last STOP cycle, accept on first IDLE cycle
    wr(32'h4, 32'hA5);
    idle(49);
    wr(32'h4, 32'h55);
    chk("drop_mid_txd", {31'd0, txd}, 32'd0);
    idle(15);
    chk("drop_bit6_txd", {31'd0, txd}, 32'd1);
    idle(34);
    wr(32'h4, 32'h3C);
    chk("stop_edge_idle", {31'd0, txd}, 32'd1);
    wr(32'h4, 32'h0F);
    chk("b2b_start", {31'd0, txd}, 32'd0);
    idle(15);
    chk("b2b_bit0", {31'd0, txd}, 32'd1);
    idle(100);

    // Reset mid-frame, with strobes ignored during reset
    wr(32'h4, 32'hA5);
    idle(34);
    rst = 1'b1;
    io_sel = 1'b1; io_wstrb = 1'b1; io_addr = 32'h0; io_wdata = 32'h1F;
    @(negedge clk);
    io_sel = 1'b0; io_wstrb = 1'b0;
    rst = 1'b0;
    chk("midrst_txd", {31'd0, txd}, 32'd1);
    chk("midrst_leds", {27'd0, leds}, 32'd0);
    idle(3);
    rd(32'h8, v);  chk("midrst_status", v, 32'h2);
    low_cnt = 0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (txd !== 1'b1) low_cnt++;
    end
    chk("midrst_no_resume", 32'(low_cnt), 32'd0);

    // Counter wrap
    force dut.cycles_q = 32'hFFFF_FFFE;
    cyc_forced = 1'b1;
    @(negedge clk);
    release dut.cycles_q;
    cyc_forced = 1'b0;
    io_sel = 1'b1; io_rstrb = 1'b1; io_addr = 32'hC;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("wrap_%0d", i), io_rdata, 32'hFFFF_FFFE + 32'(i));
    end
    io_sel = 1'b0; io_rstrb = 1'b0;
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
